log_fpmul_serial: RTL and testbench

Parametrised, byte-serial floating-point multiplier for the TinyTapeout-style 8-bit pin budget. It collects two operands over a valid/ready byte stream and multiplies them in one of two run-time modes: Mitchell logarithmic approximation or exact truncated product. The result and exception flags are returned over a second valid/ready byte stream. It replaces the fixed FP16, free-running-collect multiplier with generic `EXP_W`/`MAN_W`, proper handshakes, and IEEE special-case handling.

---
 rtl/log_fpmul_pkg.sv | 22 ++
 rtl/log_fpmul_serial_core.sv | 82 ++++++++
 rtl/log_fpmul_serial.sv | 132 +++++++++++++
 tb/tb_log_fpmul_serial.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/log_fpmul_pkg.sv
// Shared types and helpers for the byte-serial log/exact floating-point multiplier.
package log_fpmul_pkg;

    typedef enum logic [1:0] {
        LOAD,
        CALC,
        SEND
    } state_e;

    localparam int INVALID   = 2;
    localparam int OVERFLOW  = 1;
    localparam int UNDERFLOW = 0;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int nbytes(input int exp_w, input int man_w);
        return (1 + exp_w + man_w + 7) / 8;
    endfunction

endpackage

// File: rtl/log_fpmul_serial_core.sv
// Combinational FP multiply: Mitchell approximation (mode 0) or truncated exact product (mode 1),
// with subnormal flush-to-zero, IEEE special cases and range flags.
module fpmul_core
    import log_fpmul_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic [EXP_W+MAN_W:0] a_i,
    input  logic [EXP_W+MAN_W:0] b_i,
    input  logic                 mode_i,
    output logic [EXP_W+MAN_W:0] result_o,
    output logic [2:0]           flags_o
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam logic [EXP_W+1:0] BIAS_V = (EXP_W + 2)'(bias(EXP_W));
    localparam logic [EXP_W+1:0] EMAX_V = (EXP_W + 2)'((1 << EXP_W) - 1);
    localparam logic [MAN_W-1:0] QNAN_M = MAN_W'(1) << (MAN_W - 1);
    localparam logic [W-1:0]     QNAN   = {1'b0, {EXP_W{1'b1}}, QNAN_M};

    logic             signA, signB, sign;
    logic [EXP_W-1:0] expA, expB;
    logic [MAN_W-1:0] manA, manB, man;
    logic             zeroA, zeroB, infA, infB, nanA, nanB;
    logic [MAN_W:0]   manSum;
    logic [PW-1:0]    prod;
    logic             carry;
    logic [EXP_W+1:0] expSum;
    logic             unused_prod;

    assign signA = a_i[W-1];
    assign signB = b_i[W-1];
    assign expA  = a_i[W-2 -: EXP_W];
    assign expB  = b_i[W-2 -: EXP_W];
    assign manA  = a_i[MAN_W-1:0];
    assign manB  = b_i[MAN_W-1:0];
    assign sign  = signA ^ signB;

    assign zeroA = (expA == '0);
    assign zeroB = (expB == '0);
    assign infA  = (&expA) && (manA == '0);
    assign infB  = (&expB) && (manB == '0);
    assign nanA  = (&expA) && (manA != '0);
    assign nanB  = (&expB) && (manB != '0);

    // Mitchell adds the fractional log2 parts directly; a carry means the product crossed 2.0.
    assign manSum = {1'b0, manA} + {1'b0, manB};
    assign prod   = PW'({1'b1, manA}) * PW'({1'b1, manB});
    assign carry  = mode_i ? prod[PW-1] : manSum[MAN_W];

    always_comb begin
        man = manSum[MAN_W-1:0];
        if (mode_i) begin
            man = carry ? prod[2*MAN_W:MAN_W+1] : prod[2*MAN_W-1:MAN_W];
        end
    end

    // Two guard bits keep the biased exponent sum unambiguous: MSB set means it went negative.
    assign expSum = {2'b00, expA} + {2'b00, expB} + {{(EXP_W + 1){1'b0}}, carry} - BIAS_V;
    assign unused_prod = ^prod[MAN_W-1:0];

    always_comb begin
        result_o = {sign, expSum[EXP_W-1:0], man};
        flags_o  = '0;
        if (nanA || nanB || (infA && zeroB) || (zeroA && infB)) begin
            result_o         = QNAN;
            flags_o[INVALID] = 1'b1;
        end else if (infA || infB) begin
            result_o = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (zeroA || zeroB) begin
            result_o = {sign, {(W - 1){1'b0}}};
        end else if (expSum[EXP_W+1] || (expSum == '0)) begin
            result_o           = {sign, {(W - 1){1'b0}}};
            flags_o[UNDERFLOW] = 1'b1;
        end else if (expSum >= EMAX_V) begin
            result_o          = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_o[OVERFLOW] = 1'b1;
        end
    end

endmodule

// File: rtl/log_fpmul_serial.sv
// Byte-serial wrapper: collects A/B LSB byte first, multiplies in one CALC cycle,
// then streams the result back LSB byte first with flags held for the whole word.
module log_fpmul_serial
    import log_fpmul_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic       mode,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [2:0] out_flags
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int NB    = nbytes(EXP_W, MAN_W);
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [NB*8-1:0]  aWord_q, aWord_d;
    logic [NB*8-1:0]  bWord_q, bWord_d;
    logic [NB*8-1:0]  res_q, res_d;
    logic             mode_q, mode_d;
    logic [2:0]       flags_q, flags_d;
    logic [W-1:0]     coreRes;
    logic [2:0]       coreFlags;
    logic             unused_words;

    fpmul_core #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) uCore (
        .a_i     (aWord_q[W-1:0]),
        .b_i     (bWord_q[W-1:0]),
        .mode_i  (mode_q),
        .result_o(coreRes),
        .flags_o (coreFlags)
    );

    // Padding bits above W in the last input byte are stored but never used.
    assign unused_words = ^{aWord_q, bWord_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD;
            idx_q   <= '0;
            aWord_q <= '0;
            bWord_q <= '0;
            res_q   <= '0;
            mode_q  <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            aWord_q <= aWord_d;
            bWord_q <= bWord_d;
            res_q   <= res_d;
            mode_q  <= mode_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        aWord_d   = aWord_q;
        bWord_d   = bWord_q;
        res_d     = res_q;
        mode_d    = mode_q;
        flags_d   = flags_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    aWord_d[{idx_q, 3'b000} +: 8] = in_a;
                    bWord_d[{idx_q, 3'b000} +: 8] = in_b;
                    if (idx_q == '0) begin
                        mode_d = mode;
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = CALC;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            CALC: begin
                res_d          = '0;
                res_d[W-1:0]   = coreRes;
                flags_d        = coreFlags;
                state_d        = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = LOAD;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = LOAD;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs read as zero outside SEND so idle and reset values match.
    always_comb begin
        out_data  = '0;
        out_flags = '0;
        if (state_q == SEND) begin
            out_data  = res_q[{idx_q, 3'b000} +: 8];
            out_flags = flags_q;
        end
    end

endmodule

// File: tb/tb_log_fpmul_serial.sv
// Self-checking bench for log_fpmul_serial: FP16 directed/random/protocol tests plus an FP32 instance.
module tb_log_fpmul_serial;
    localparam int EW = 5;
    localparam int MW = 10;
    localparam int NB = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inValid = 1'b0;
    logic       inReady;
    logic [7:0] inA = '0;
    logic [7:0] inB = '0;
    logic       mode = 1'b0;
    logic       outValid;
    logic       outReady = 1'b0;
    logic [7:0] outData;
    logic [2:0] outFlags;

    logic       v32 = 1'b0;
    logic       r32;
    logic [7:0] a32 = '0;
    logic [7:0] b32 = '0;
    logic       m32 = 1'b0;
    logic       ov32;
    logic       rdy32 = 1'b1;
    logic [7:0] d32;
    logic [2:0] f32;

    int errors = 0;
    int checks = 0;
    int cycle = 0;

    log_fpmul_serial #(.EXP_W(EW), .MAN_W(MW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady),
        .in_a(inA), .in_b(inB), .mode(mode), .out_valid(outValid),
        .out_ready(outReady), .out_data(outData), .out_flags(outFlags)
    );

    log_fpmul_serial #(.EXP_W(8), .MAN_W(23)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(r32),
        .in_a(a32), .in_b(b32), .mode(m32), .out_valid(ov32),
        .out_ready(rdy32), .out_data(d32), .out_flags(f32)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference multiply from the number-format rules using plain integer arithmetic.
    function automatic void refMul(input longint a, input longint b, input bit md,
                                   input int ew, input int mw,
                                   output longint res, output logic [2:0] fl);
        longint emax, bias, one, sa, sb, ea, eb, ma, mb, s, e, frac, prod;
        bit nanA, nanB, infA, infB, zA, zB;
        emax = (longint'(1) << ew) - 1;
        bias = (longint'(1) << (ew - 1)) - 1;
        one  = longint'(1) << mw;
        sa = (a >> (ew + mw)) & 1;
        sb = (b >> (ew + mw)) & 1;
        ea = (a >> mw) & emax;
        eb = (b >> mw) & emax;
        ma = a & (one - 1);
        mb = b & (one - 1);
        nanA = (ea == emax) && (ma != 0);
        nanB = (eb == emax) && (mb != 0);
        infA = (ea == emax) && (ma == 0);
        infB = (eb == emax) && (mb == 0);
        zA = (ea == 0);
        zB = (eb == 0);
        s = sa ^ sb;
        fl = 3'b000;
        if (nanA || nanB || (infA && zB) || (zA && infB)) begin
            res = (emax << mw) | (one >> 1);
            fl = 3'b100;
            return;
        end
        if (infA || infB) begin
            res = (s << (ew + mw)) | (emax << mw);
            return;
        end
        if (zA || zB) begin
            res = s << (ew + mw);
            return;
        end
        e = ea + eb - bias;
        if (!md) begin
            frac = ma + mb;
            if (frac >= one) begin
                e = e + 1;
                frac = frac - one;
            end
        end else begin
            prod = (one + ma) * (one + mb);
            if (prod >= 2 * one * one) begin
                e = e + 1;
                frac = prod / (2 * one) - one;
            end else begin
                frac = prod / one - one;
            end
        end
        if (e <= 0) begin
            res = s << (ew + mw);
            fl = 3'b001;
        end else if (e >= emax) begin
            res = (s << (ew + mw)) | (emax << mw);
            fl = 3'b010;
        end else begin
            res = (s << (ew + mw)) | (e << mw) | frac;
        end
    endfunction

    function automatic logic [15:0] randOp16();
        logic [4:0] e;
        logic [9:0] m;
        int k;
        k = $urandom_range(9, 0);
        m = 10'($urandom);
        case (k)
            0: e = '0;
            1: begin
                e = 5'h1F;
                if ($urandom_range(1, 0) == 1) m = '0;
            end
            default: e = 5'($urandom_range(30, 1));
        endcase
        return {1'($urandom), e, m};
    endfunction

    // Drives one word; mode is only correct on beat 0, later beats carry the inverse.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input bit md,
                                 input int maxGap, output bit timedOut);
        int gap, n;
        bit hs;
        timedOut = 1'b0;
        for (int i = 0; i < NB; i++) begin
            gap = (maxGap > 0) ? $urandom_range(maxGap, 0) : 0;
            inValid = 1'b0;
            repeat (gap) begin
                inA = 8'($urandom);
                inB = 8'($urandom);
                @(posedge clk); #1;
            end
            inA = a[i*8 +: 8];
            inB = b[i*8 +: 8];
            mode = (i == 0) ? md : ~md;
            inValid = 1'b1;
            n = 0;
            do begin
                hs = inReady;
                @(posedge clk); #1;
                n++;
            end while (!hs && n < 200);
            if (!hs) timedOut = 1'b1;
        end
        inValid = 1'b0;
        inA = 8'($urandom);
        inB = 8'($urandom);
        mode = 1'($urandom);
    endtask

    // Collects one result word with random stalls, noting any change of data/flags while stalled.
    task automatic checkOutput(input int maxStall, output logic [15:0] res, output logic [2:0] fl,
                               output bit timedOut, output bit unstable);
        int n, stall;
        logic [7:0] hb;
        logic [2:0] hf;
        res = '0;
        fl = '0;
        timedOut = 1'b0;
        unstable = 1'b0;
        for (int i = 0; i < NB; i++) begin
            outReady = 1'b0;
            n = 0;
            while (!outValid && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            if (!outValid) begin
                timedOut = 1'b1;
                return;
            end
            stall = (maxStall > 0) ? $urandom_range(maxStall, 0) : 0;
            hb = outData;
            hf = outFlags;
            repeat (stall) begin
                @(posedge clk); #1;
                if (!outValid || outData !== hb || outFlags !== hf) unstable = 1'b1;
            end
            if (i == 0) fl = outFlags;
            else if (outFlags !== fl) unstable = 1'b1;
            res[i*8 +: 8] = outData;
            outReady = 1'b1;
            @(posedge clk); #1;
            outReady = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", inReady); end
        checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", outValid); end
        checks++; if (outData !== 8'h00) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 00", outData); end
        checks++; if (outFlags !== 3'b000) begin errors++; $display("[TB] FAIL reset_out_flags: got %b expected 000", outFlags); end
        checks++; if (r32 !== 1'b1 || ov32 !== 1'b0) begin errors++; $display("[TB] FAIL reset_fp32: got ready=%b valid=%b expected 1/0", r32, ov32); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        bit          md;
        logic [15:0] r;
        logic [2:0]  f;
    } vec_t;

    task automatic test_directed();
        vec_t vecs[15] = '{
            '{16'h3E00, 16'h3E00, 1'b0, 16'h4000, 3'b000},
            '{16'h3E00, 16'h3E00, 1'b1, 16'h4080, 3'b000},
            '{16'h4000, 16'h4200, 1'b0, 16'h4600, 3'b000},
            '{16'h4000, 16'h4200, 1'b1, 16'h4600, 3'b000},
            '{16'h8000, 16'h4200, 1'b0, 16'h8000, 3'b000},
            '{16'h7C00, 16'h0000, 1'b1, 16'h7E00, 3'b100},
            '{16'h7C00, 16'hC000, 1'b0, 16'hFC00, 3'b000},
            '{16'h7BFF, 16'h7BFF, 1'b1, 16'h7C00, 3'b010},
            '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 3'b010},
            '{16'h0400, 16'h0400, 1'b0, 16'h0000, 3'b001},
            '{16'h2000, 16'h2000, 1'b1, 16'h0400, 3'b000},
            '{16'h1C00, 16'hA000, 1'b1, 16'h8000, 3'b001},
            '{16'h7800, 16'h3C00, 1'b0, 16'h7800, 3'b000},
            '{16'h7800, 16'hC000, 1'b1, 16'hFC00, 3'b010},
            '{16'h7C01, 16'h3C00, 1'b0, 16'h7E00, 3'b100}
        };
        logic [15:0] res;
        logic [2:0] fl;
        bit to1, to2, unst;
        foreach (vecs[k]) begin
            applyStimulus(vecs[k].a, vecs[k].b, vecs[k].md, 1, to1);
            checkOutput(1, res, fl, to2, unst);
            checks++; if (to1 || to2) begin errors++; $display("[TB] FAIL directed_timeout[%0d]: got in=%b out=%b expected 0/0", k, to1, to2); end
            checks++; if (res !== vecs[k].r) begin errors++; $display("[TB] FAIL directed_result[%0d] %h*%h m%0d: got %h expected %h", k, vecs[k].a, vecs[k].b, vecs[k].md, res, vecs[k].r); end
            checks++; if (fl !== vecs[k].f) begin errors++; $display("[TB] FAIL directed_flags[%0d]: got %b expected %b", k, fl, vecs[k].f); end
            checks++; if (unst) begin errors++; $display("[TB] FAIL directed_stable[%0d]: got unstable=1 expected 0", k); end
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, res;
        logic [2:0] fl, expF;
        longint expR;
        bit md, to1, to2, unst;
        for (int k = 0; k < 60; k++) begin
            a = randOp16();
            b = randOp16();
            md = 1'($urandom);
            refMul(longint'(a), longint'(b), md, EW, MW, expR, expF);
            applyStimulus(a, b, md, 2, to1);
            checkOutput(2, res, fl, to2, unst);
            checks++; if (to1 || to2) begin errors++; $display("[TB] FAIL random_timeout[%0d]: got in=%b out=%b expected 0/0", k, to1, to2); end
            checks++; if (res !== 16'(expR) || fl !== expF) begin errors++; $display("[TB] FAIL random[%0d] %h*%h m%0d: got %h/%b expected %h/%b", k, a, b, md, res, fl, 16'(expR), expF); end
            checks++; if (unst) begin errors++; $display("[TB] FAIL random_stable[%0d]: got unstable=1 expected 0", k); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] res;
        bit to1, notIdle;
        int n;
        applyStimulus(16'h4000, 16'h4200, 1'b0, 0, to1);
        outReady = 1'b0;
        @(posedge clk); #1;
        checks++; if (to1 || outValid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid: got %b expected 1", outValid); end
        notIdle = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (inReady !== 1'b0) notIdle = 1'b1;
            checks++; if (outValid !== 1'b1 || outData !== 8'h00) begin errors++; $display("[TB] FAIL bp_hold: got valid=%b data=%h expected 1/00", outValid, outData); end
        end
        outReady = 1'b1;
        n = 0;
        res = '0;
        while (outValid && n < 20) begin
            if (inReady !== 1'b0) notIdle = 1'b1;
            if (n < NB) res[n*8 +: 8] = outData;
            @(posedge clk); #1;
            n++;
        end
        outReady = 1'b0;
        checks++; if (n != NB) begin errors++; $display("[TB] FAIL bp_send_cycles: got %0d expected %0d", n, NB); end
        checks++; if (res !== 16'h4600) begin errors++; $display("[TB] FAIL bp_result: got %h expected 4600", res); end
        checks++; if (notIdle) begin errors++; $display("[TB] FAIL bp_in_ready: got 1 during SEND expected 0"); end
    endtask

    task automatic test_reset_midword();
        logic [15:0] res;
        logic [2:0] fl;
        bit to1, to2, unst;
        inA = 8'h55; inB = 8'hAA; mode = 1'b1; inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (inReady !== 1'b1 || outValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_load: got ready=%b valid=%b expected 1/0", inReady, outValid); end
        applyStimulus(16'h3C00, 16'h4000, 1'b0, 0, to1);
        checks++; if (to1 || inReady !== 1'b0 || outValid !== 1'b0) begin errors++; $display("[TB] FAIL latency_calc: got ready=%b valid=%b expected 0/0", inReady, outValid); end
        @(posedge clk); #1;
        checks++; if (outValid !== 1'b1 || inReady !== 1'b0) begin errors++; $display("[TB] FAIL latency_send: got valid=%b ready=%b expected 1/0", outValid, inReady); end
        checkOutput(0, res, fl, to2, unst);
        checks++; if (to2 || res !== 16'h4000 || fl !== 3'b000) begin errors++; $display("[TB] FAIL rst_load_result: got %h/%b expected 4000/000", res, fl); end

        applyStimulus(16'h3E00, 16'h3E00, 1'b1, 0, to1);
        @(posedge clk); #1;
        checks++; if (outValid !== 1'b1 || outData !== 8'h80) begin errors++; $display("[TB] FAIL rst_send_pre: got valid=%b data=%h expected 1/80", outValid, outData); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (outValid !== 1'b0 || outData !== 8'h00 || outFlags !== 3'b000 || inReady !== 1'b1) begin errors++; $display("[TB] FAIL rst_send: got valid=%b data=%h flags=%b ready=%b expected 0/00/000/1", outValid, outData, outFlags, inReady); end
        applyStimulus(16'h4000, 16'h4200, 1'b1, 0, to1);
        checkOutput(1, res, fl, to2, unst);
        checks++; if (to1 || to2 || res !== 16'h4600 || fl !== 3'b000) begin errors++; $display("[TB] FAIL rst_send_result: got %h/%b expected 4600/000", res, fl); end
    endtask

    task automatic test_back_to_back();
        int starts[3];
        int n;
        bit hs, to;
        to = 1'b0;
        outReady = 1'b1;
        inValid = 1'b1;
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < NB; i++) begin
                inA = 8'($urandom);
                inB = 8'($urandom);
                mode = 1'($urandom);
                n = 0;
                do begin
                    hs = inReady;
                    @(posedge clk); #1;
                    n++;
                end while (!hs && n < 50);
                if (!hs) to = 1'b1;
                if (i == 0) starts[w] = cycle;
            end
        end
        inValid = 1'b0;
        repeat (2 * NB + 2) @(posedge clk);
        #1;
        outReady = 1'b0;
        checks++; if (to) begin errors++; $display("[TB] FAIL b2b_timeout: got 1 expected 0"); end
        checks++; if (starts[1] - starts[0] != 2 * NB + 1) begin errors++; $display("[TB] FAIL b2b_period0: got %0d expected %0d", starts[1] - starts[0], 2 * NB + 1); end
        checks++; if (starts[2] - starts[1] != 2 * NB + 1) begin errors++; $display("[TB] FAIL b2b_period1: got %0d expected %0d", starts[2] - starts[1], 2 * NB + 1); end
    endtask

    task automatic test_fp32();
        logic [31:0] ops[6][2];
        logic [31:0] res, expR32;
        logic [2:0] fl, expF;
        longint expR;
        bit md, hs;
        int n;
        ops[0] = '{32'h3FC00000, 32'h3FC00000};
        ops[1] = '{32'h3FC00000, 32'h3FC00000};
        for (int k = 2; k < 6; k++) begin
            ops[k][0] = {1'($urandom), 8'($urandom_range(200, 60)), 23'($urandom)};
            ops[k][1] = {1'($urandom), 8'($urandom_range(200, 60)), 23'($urandom)};
        end
        for (int k = 0; k < 6; k++) begin
            md = (k == 0) ? 1'b1 : (k == 1) ? 1'b0 : 1'($urandom);
            refMul(longint'(ops[k][0]), longint'(ops[k][1]), md, 8, 23, expR, expF);
            expR32 = 32'(expR);
            if (k == 0) expR32 = 32'h40100000;
            if (k == 1) expR32 = 32'h40000000;
            for (int i = 0; i < 4; i++) begin
                a32 = ops[k][0][i*8 +: 8];
                b32 = ops[k][1][i*8 +: 8];
                m32 = (i == 0) ? md : ~md;
                v32 = 1'b1;
                n = 0;
                do begin
                    hs = r32;
                    @(posedge clk); #1;
                    n++;
                end while (!hs && n < 50);
            end
            v32 = 1'b0;
            n = 0;
            while (!ov32 && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            fl = f32;
            res = '0;
            for (int i = 0; i < 4; i++) begin
                res[i*8 +: 8] = d32;
                @(posedge clk); #1;
            end
            checks++; if (res !== expR32 || fl !== expF) begin errors++; $display("[TB] FAIL fp32[%0d] %h*%h m%0d: got %h/%b expected %h/%b", k, ops[k][0], ops[k][1], md, res, fl, expR32, expF); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midword();
        test_back_to_back();
        test_random();
        test_fp32();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
